// File: rtl/display_scheduler.sv
// -----------------------------------------------------------------------------
// display_scheduler
//
// Time-multiplexes an NDIG-digit common-anode 7-segment display from a short
// history of accepted keypad digits. Every key strobe shifts into the history
// (newest digit at index 0). A blank/dwell timer visits the anodes one at a
// time with all-off dead-time between digits so segments never ghost across.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   key        hex value of the accepted key
//   key_valid  one-cycle strobe, key is shifted into the history
//   clear      one-cycle strobe, empties the history (wins over key_valid)
//   anode_n    per-digit anode enable, active-low, registered
//   digit      hex value for the segment decoder, registered
//   digit_idx  index of the digit being driven, registered
//   seg_en     decoder segment enable, registered
// -----------------------------------------------------------------------------
module display_scheduler #(
   parameter int NDIG  = 2,
   parameter int DWELL = 1000,
   parameter int BLANK = 50,
   localparam int IDXW = $clog2(NDIG)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [3:0]      key,
   input  logic            key_valid,
   input  logic            clear,
   output logic [NDIG-1:0] anode_n,
   output logic [3:0]      digit,
   output logic [IDXW-1:0] digit_idx,
   output logic            seg_en
);

   localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [TW-1:0]   BLANK_LAST = TW'(BLANK - 1);
   localparam logic [TW-1:0]   DWELL_LAST = TW'(DWELL - 1);
   localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NDIG - 1);

   typedef enum logic [1:0] {
      S_BLANK = 2'b00,
      S_ON    = 2'b01
   } state_t;

   // ---------------------------------------------------------------------------
   // Digit history: shift register of {valid, value}
   // ---------------------------------------------------------------------------
   logic [NDIG-1:0][3:0] hist_q, hist_d;
   logic [NDIG-1:0]      valid_q, valid_d;

   genvar gi;
   generate
      for (gi = 0; gi < NDIG; gi++) begin : g_hist
         logic [3:0] src_val;
         logic       src_vld;
         if (gi == 0) begin : g_head
            assign src_val = key;
            assign src_vld = 1'b1;
         end else begin : g_tail
            assign src_val = hist_q[gi-1];
            assign src_vld = valid_q[gi-1];
         end
         // clear has priority: a key arriving with clear is discarded
         assign hist_d[gi]  = clear ? 4'h0 : (key_valid ? src_val : hist_q[gi]);
         assign valid_d[gi] = clear ? 1'b0 : (key_valid ? src_vld : valid_q[gi]);
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Scan state machine
   // ---------------------------------------------------------------------------
   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [NDIG-1:0] anode_n_q, anode_n_d;
   logic [3:0]      digit_q, digit_d;
   logic [IDXW-1:0] digit_idx_q, digit_idx_d;
   logic            seg_en_q, seg_en_d;

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q + TW'(1);
      idx_d       = idx_q;
      anode_n_d   = anode_n_q;
      digit_d     = digit_q;
      digit_idx_d = digit_idx_q;
      seg_en_d    = seg_en_q;

      case (state_q)
         S_BLANK: begin
            anode_n_d = '1;
            seg_en_d  = 1'b0;
            if (timer_q == BLANK_LAST) begin
               // Capture the slot's value once; history changes during the
               // dwell are only seen at this index's next capture.
               digit_d            = hist_q[idx_q];
               digit_idx_d        = idx_q;
               seg_en_d           = valid_q[idx_q];
               anode_n_d[idx_q]   = ~valid_q[idx_q];
               state_d            = S_ON;
               timer_d            = '0;
            end
         end

         S_ON: begin
            if (clear) begin
               // Go dark immediately; the same digit slot is retried.
               anode_n_d = '1;
               seg_en_d  = 1'b0;
               state_d   = S_BLANK;
               timer_d   = '0;
            end else if (timer_q == DWELL_LAST) begin
               anode_n_d = '1;
               seg_en_d  = 1'b0;
               idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDXW'(1);
               state_d   = S_BLANK;
               timer_d   = '0;
            end
         end

         default: begin
            anode_n_d = '1;
            seg_en_d  = 1'b0;
            state_d   = S_BLANK;
            timer_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q      <= '0;
         valid_q     <= '0;
         state_q     <= S_BLANK;
         timer_q     <= '0;
         idx_q       <= '0;
         anode_n_q   <= '1;
         digit_q     <= 4'h0;
         digit_idx_q <= '0;
         seg_en_q    <= 1'b0;
      end else begin
         hist_q      <= hist_d;
         valid_q     <= valid_d;
         state_q     <= state_d;
         timer_q     <= timer_d;
         idx_q       <= idx_d;
         anode_n_q   <= anode_n_d;
         digit_q     <= digit_d;
         digit_idx_q <= digit_idx_d;
         seg_en_q    <= seg_en_d;
      end
   end

   assign anode_n   = anode_n_q;
   assign digit     = digit_q;
   assign digit_idx = digit_idx_q;
   assign seg_en    = seg_en_q;

endmodule

// File: tb/tb_display_scheduler.sv
// -----------------------------------------------------------------------------
// tb_display_scheduler
//
// Bench for display_scheduler with NDIG=2, DWELL=4, BLANK=2: a cycle table from
// reset, hand-written sequences for multi-cycle corners, then random strobes
// checked against a slot-timing reference model.
// -----------------------------------------------------------------------------
module tb_display_scheduler;

   localparam int NDIG  = 2;
   localparam int DWELL = 4;
   localparam int BLANK = 2;
   localparam int SLOT  = BLANK + DWELL;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [3:0]      key = 4'h0;
   logic            key_valid = 1'b0;
   logic            clear = 1'b0;
   logic [NDIG-1:0] anode_n;
   logic [3:0]      digit;
   logic [0:0]      digit_idx;
   logic            seg_en;

   display_scheduler #(.NDIG(NDIG), .DWELL(DWELL), .BLANK(BLANK)) dut (
      .clk       (clk),
      .reset     (reset),
      .key       (key),
      .key_valid (key_valid),
      .clear     (clear),
      .anode_n   (anode_n),
      .digit     (digit),
      .digit_idx (digit_idx),
      .seg_en    (seg_en)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: drive inputs, take the edge, sample 1 time unit later.
   task automatic cyc(input logic kv, input logic [3:0] k, input logic cl);
      key_valid = kv;
      key       = k;
      clear     = cl;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      clear     = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Run until digit idx is lit (bounded by two frames).
   task automatic wait_lit(input int idx, input string name);
      int n = 0;
      while (!(anode_n[idx] == 1'b0 && int'(digit_idx) == idx) && n < 2 * NDIG * SLOT) begin
         cyc(1'b0, 4'h0, 1'b0);
         n++;
      end
      chk({name, "_lit"}, (anode_n[idx] == 1'b0 && int'(digit_idx) == idx), 1);
   endtask

   // Run until digit_idx reports idx (bounded).
   task automatic wait_idx(input int idx, input string name);
      int n = 0;
      while (int'(digit_idx) != idx && n < 2 * NDIG * SLOT) begin
         cyc(1'b0, 4'h0, 1'b0);
         n++;
      end
      chk({name, "_idx"}, digit_idx, idx);
   endtask

   typedef struct {
      logic            kv;
      logic [3:0]      key;
      logic            clr;
      logic [NDIG-1:0] an;
      logic [3:0]      dig;
      logic            idx;
      logic            seg;
   } vec_t;

   vec_t tbl[20];

   // Reference model state: history plus position within the current slot.
   logic [3:0]      m_hk[NDIG];
   logic            m_hv[NDIG];
   int              m_slot;
   int              m_t;
   logic [NDIG-1:0] m_an;
   logic [3:0]      m_dig;
   int              m_idx;
   logic            m_seg;

   task automatic model_reset();
      for (int i = 0; i < NDIG; i++) begin
         m_hk[i] = 4'h0;
         m_hv[i] = 1'b0;
      end
      m_slot = 0;
      m_t    = 0;
      m_an   = '1;
      m_dig  = 4'h0;
      m_idx  = 0;
      m_seg  = 1'b0;
   endtask

   task automatic model_step(input logic kv, input logic [3:0] k, input logic cl);
      if (m_t < BLANK) begin
         m_an  = '1;
         m_seg = 1'b0;
         if (m_t == BLANK - 1) begin
            m_dig = m_hk[m_slot];
            m_idx = m_slot;
            m_seg = m_hv[m_slot];
            if (m_hv[m_slot]) m_an[m_slot] = 1'b0;
         end
         m_t++;
      end else if (cl) begin
         m_an  = '1;
         m_seg = 1'b0;
         m_t   = 0;
      end else if (m_t == SLOT - 1) begin
         m_an   = '1;
         m_seg  = 1'b0;
         m_slot = (m_slot + 1) % NDIG;
         m_t    = 0;
      end else begin
         m_t++;
      end
      if (cl) begin
         for (int i = 0; i < NDIG; i++) begin
            m_hk[i] = 4'h0;
            m_hv[i] = 1'b0;
         end
      end else if (kv) begin
         for (int i = NDIG - 1; i > 0; i--) begin
            m_hk[i] = m_hk[i-1];
            m_hv[i] = m_hv[i-1];
         end
         m_hk[0] = k;
         m_hv[0] = 1'b1;
      end
   endtask

   initial begin
      int bad_an, bad_seg, bad_idx, bad_dig, exp_idx;
      logic kv, cl;
      logic [3:0] k;

      // Edges 1..20 after reset release; keys 5 then 9 land during idx0's
      // (dark) dwell, so idx1 shows 5 first, then idx0 shows 9.
      tbl[0]  = '{1'b0, 4'h0, 1'b0, 2'b11, 4'h0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 4'h0, 1'b0, 2'b11, 4'h0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 4'h5, 1'b0, 2'b11, 4'h0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 4'h9, 1'b0, 2'b11, 4'h0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 4'h0, 1'b0, 2'b11, 4'h0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 4'h0, 1'b0, 2'b11, 4'h0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 4'h0, 1'b0, 2'b11, 4'h0, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 4'h0, 1'b0, 2'b01, 4'h5, 1'b1, 1'b1};
      tbl[8]  = '{1'b0, 4'h0, 1'b0, 2'b01, 4'h5, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 4'h0, 1'b0, 2'b01, 4'h5, 1'b1, 1'b1};
      tbl[10] = '{1'b0, 4'h0, 1'b0, 2'b01, 4'h5, 1'b1, 1'b1};
      tbl[11] = '{1'b0, 4'h0, 1'b0, 2'b11, 4'h5, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 4'h0, 1'b0, 2'b11, 4'h5, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 4'h0, 1'b0, 2'b10, 4'h9, 1'b0, 1'b1};
      tbl[14] = '{1'b0, 4'h0, 1'b0, 2'b10, 4'h9, 1'b0, 1'b1};
      tbl[15] = '{1'b0, 4'h0, 1'b0, 2'b10, 4'h9, 1'b0, 1'b1};
      tbl[16] = '{1'b0, 4'h0, 1'b0, 2'b10, 4'h9, 1'b0, 1'b1};
      tbl[17] = '{1'b0, 4'h0, 1'b0, 2'b11, 4'h9, 1'b0, 1'b0};
      tbl[18] = '{1'b0, 4'h0, 1'b0, 2'b11, 4'h9, 1'b0, 1'b0};
      tbl[19] = '{1'b0, 4'h0, 1'b0, 2'b01, 4'h5, 1'b1, 1'b1};

      // ---- 1. reset, then three dark frames ----
      #12;
      chk("rst_anode", anode_n, 2'b11);
      chk("rst_seg", seg_en, 1'b0);
      chk("rst_digit", digit, 4'h0);
      chk("rst_idx", digit_idx, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      bad_an = 0; bad_seg = 0; bad_idx = 0;
      for (int e = 1; e <= 3 * NDIG * SLOT; e++) begin
         cyc(1'b0, 4'h0, 1'b0);
         exp_idx = (e < BLANK) ? 0 : ((e - BLANK) / SLOT) % NDIG;
         if (anode_n !== 2'b11) bad_an++;
         if (seg_en !== 1'b0) bad_seg++;
         if (int'(digit_idx) != exp_idx) bad_idx++;
      end
      chk("idle_anode_bad_cycles", bad_an, 0);
      chk("idle_seg_bad_cycles", bad_seg, 0);
      chk("idle_idx_bad_cycles", bad_idx, 0);

      // ---- 2. table from a fresh reset ----
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cyc(tbl[i].kv, tbl[i].key, tbl[i].clr);
         chk($sformatf("tbl%0d_anode", i + 1), anode_n, tbl[i].an);
         chk($sformatf("tbl%0d_digit", i + 1), digit, tbl[i].dig);
         chk($sformatf("tbl%0d_idx", i + 1), digit_idx, tbl[i].idx);
         chk($sformatf("tbl%0d_seg", i + 1), seg_en, tbl[i].seg);
      end

      // ---- 3. key 3 after 9,5: shows 3,9 ----
      cyc(1'b1, 4'h3, 1'b0);
      wait_lit(0, "k3_d0");
      chk("k3_d0_digit", digit, 4'h3);
      wait_lit(1, "k3_d1");
      chk("k3_d1_digit", digit, 4'h9);

      // ---- 4. key A in the 2nd dwell cycle of digit 0 ----
      wait_lit(0, "ka_d0");
      chk("ka_d0_digit", digit, 4'h3);
      cyc(1'b0, 4'h0, 1'b0);
      cyc(1'b1, 4'hA, 1'b0);
      bad_dig = 0;
      for (int n = 0; n < SLOT && anode_n == 2'b10; n++) begin
         if (digit !== 4'h3) bad_dig++;
         cyc(1'b0, 4'h0, 1'b0);
      end
      chk("ka_hold_bad_cycles", bad_dig, 0);
      chk("ka_dwell_ended", anode_n, 2'b11);
      wait_lit(1, "ka_d1");
      chk("ka_d1_digit", digit, 4'h3);
      wait_lit(0, "ka_d0b");
      chk("ka_d0b_digit", digit, 4'hA);

      // ---- 5. clear + key in the same cycle during S_ON ----
      cyc(1'b1, 4'h7, 1'b1);
      chk("clr_anode", anode_n, 2'b11);
      chk("clr_seg", seg_en, 1'b0);
      bad_an = 0;
      for (int n = 0; n < 2 * NDIG * SLOT; n++) begin
         cyc(1'b0, 4'h0, 1'b0);
         if (anode_n !== 2'b11 || seg_en !== 1'b0) bad_an++;
      end
      chk("clr_dark_bad_cycles", bad_an, 0);
      cyc(1'b1, 4'h7, 1'b0);
      wait_lit(0, "k7_d0");
      chk("k7_d0_anode", anode_n, 2'b10);
      chk("k7_d0_digit", digit, 4'h7);
      wait_idx(1, "k7_d1");
      bad_an = 0;
      for (int n = 0; n < DWELL; n++) begin
         if (anode_n !== 2'b11) bad_an++;
         cyc(1'b0, 4'h0, 1'b0);
      end
      chk("k7_d1_dark_bad_cycles", bad_an, 0);

      // ---- 6. asynchronous reset mid-dwell ----
      wait_lit(0, "ar_d0");
      cyc(1'b0, 4'h0, 1'b0);
      #3;
      reset = 1'b1;
      #1;
      chk("arst_anode", anode_n, 2'b11);
      chk("arst_seg", seg_en, 1'b0);
      chk("arst_digit", digit, 4'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      bad_an = 0;
      for (int e = 1; e <= BLANK + SLOT; e++) begin
         cyc(1'b0, 4'h0, 1'b0);
         if (anode_n !== 2'b11 || seg_en !== 1'b0) bad_an++;
         if (e == BLANK + DWELL + 1) chk("arst_idx_before", digit_idx, 1'b0);
      end
      chk("arst_idx_second_capture", digit_idx, 1'b1);
      for (int n = 0; n < NDIG * SLOT; n++) begin
         cyc(1'b0, 4'h0, 1'b0);
         if (anode_n !== 2'b11 || seg_en !== 1'b0) bad_an++;
      end
      chk("arst_dark_bad_cycles", bad_an, 0);

      // ---- random strobes against the reference model ----
      do_reset();
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         kv = ($urandom_range(0, 7) == 0);
         cl = ($urandom_range(0, 39) == 0);
         k  = 4'($urandom_range(0, 15));
         model_step(kv, k, cl);
         cyc(kv, k, cl);
         chk($sformatf("rnd%0d_anode", n), anode_n, m_an);
         chk($sformatf("rnd%0d_digit", n), digit, m_dig);
         chk($sformatf("rnd%0d_idx", n), digit_idx, m_idx);
         chk($sformatf("rnd%0d_seg", n), seg_en, m_seg);
         chk($sformatf("rnd%0d_one_anode", n), ($countones(~anode_n) <= 1), 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
